cache_mem_arbiter: RTL and testbench

- Memory-side responder for the cache_control protocol.
- Accepts per-core icache read requests (iREN/iaddr) and dcache read/write requests (dREN/dWEN/daddr/dstore).
- Arbitrates among them, drives the single RAM port and returns iwait/dwait/iload/dload to the requesting caches.
- Sits between the caches of all cores and the RAM model/controller.

---
 rtl/cache_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Memory-side arbiter for per-core icache/dcache requests onto a single RAM port.
// Optional grant counters (igrants/dgrants) are built when ARB_PERF_EN is defined.
module cache_mem_arbiter #(
    parameter int unsigned CPUS = 2
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [32*CPUS-1:0]   iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [32*CPUS-1:0]   iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [32*CPUS-1:0]   daddr,
    input  logic [32*CPUS-1:0]   dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [32*CPUS-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
`ifdef ARB_PERF_EN
    output logic [31:0]          igrants,
    output logic [31:0]          dgrants,
`endif
    input  logic [1:0]           ramstate
);

    localparam int unsigned GntW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0]  RamAccess = 2'd2;

    typedef enum logic [1:0] {StIdle, StDgrant, StIgrant} state_e;

    state_e            state_q, state_d;
    logic [GntW-1:0]   gnt_q, gnt_d;
    logic [GntW-1:0]   dlast_q, dlast_d;
    logic [GntW-1:0]   ilast_q, ilast_d;
    logic [CPUS-1:0]   dreq;
    logic              i_done, d_done;
    logic [31:0]       iaddr_a  [CPUS];
    logic [31:0]       daddr_a  [CPUS];
    logic [31:0]       dstore_a [CPUS];

    for (genvar k = 0; k < CPUS; k++) begin : g_unpack
        assign iaddr_a[k]  = iaddr[32*k +: 32];
        assign daddr_a[k]  = daddr[32*k +: 32];
        assign dstore_a[k] = dstore[32*k +: 32];
    end

    assign dreq  = dREN | dWEN;
    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // Lowest requester above last wins; otherwise wrap to the lowest requester overall.
    function automatic logic [GntW-1:0] rr_pick(input logic [CPUS-1:0] req,
                                                input logic [GntW-1:0] last);
        logic [GntW-1:0] sel;
        logic            hi;
        sel = last;
        hi  = 1'b0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            if (req[k] && (k > int'(last))) begin
                sel = GntW'(k);
                hi  = 1'b1;
            end
        end
        if (!hi) begin
            for (int k = CPUS - 1; k >= 0; k--) begin
                if (req[k]) sel = GntW'(k);
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        dlast_d  = dlast_q;
        ilast_d  = ilast_q;
        iwait    = '1;
        dwait    = '1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|dreq) begin
                    state_d = StDgrant;
                    gnt_d   = rr_pick(dreq, dlast_q);
                end else if (|iREN) begin
                    state_d = StIgrant;
                    gnt_d   = rr_pick(iREN, ilast_q);
                end
            end
            StDgrant: begin
                ramaddr = daddr_a[gnt_q];
                if (!dreq[gnt_q]) begin
                    state_d = StIdle;
                end else begin
                    if (dWEN[gnt_q]) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore_a[gnt_q];
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (ramstate == RamAccess) begin
                        dwait[gnt_q] = 1'b0;
                        d_done       = 1'b1;
                        state_d      = StIdle;
                        dlast_d      = gnt_q;
                    end
                end
            end
            StIgrant: begin
                ramaddr = iaddr_a[gnt_q];
                if (!iREN[gnt_q]) begin
                    state_d = StIdle;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == RamAccess) begin
                        iwait[gnt_q] = 1'b0;
                        i_done       = 1'b1;
                        state_d      = StIdle;
                        ilast_d      = gnt_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            dlast_q <= GntW'(CPUS - 1);
            ilast_q <= GntW'(CPUS - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            dlast_q <= dlast_d;
            ilast_q <= ilast_d;
        end
    end

`ifdef ARB_PERF_EN
    logic [31:0] igrants_q, igrants_d;
    logic [31:0] dgrants_q, dgrants_d;

    always_comb begin
        igrants_d = igrants_q + {31'd0, i_done};
        dgrants_d = dgrants_q + {31'd0, d_done};
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            igrants_q <= '0;
            dgrants_q <= '0;
        end else begin
            igrants_q <= igrants_d;
            dgrants_q <= dgrants_d;
        end
    end

    assign igrants = igrants_q;
    assign dgrants = dgrants_q;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter against a transaction-level reference model.
module tb_cache_mem_arbiter;

    localparam int CPUS = 2;

    logic                clk = 1'b0;
    logic                nRST;
    logic [CPUS-1:0]     iREN, dREN, dWEN;
    logic [32*CPUS-1:0]  iaddr, daddr, dstore;
    logic [CPUS-1:0]     iwait, dwait;
    logic [32*CPUS-1:0]  iload, dload;
    logic                ramREN, ramWEN;
    logic [31:0]         ramaddr, ramstore, ramload;
    logic [1:0]          ramstate;
`ifdef ARB_PERF_EN
    logic [31:0]         igrants, dgrants;
`endif

    int checks = 0;
    int errors = 0;

    // Model: an outstanding grant (class + core), per-class last-served pointers, counts.
    bit          m_busy;
    bit          m_isd;
    int          m_core;
    int          m_dptr, m_iptr;
    int unsigned m_icnt, m_dcnt;

    cache_mem_arbiter #(.CPUS(CPUS)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
`ifdef ARB_PERF_EN
        .igrants  (igrants),
        .dgrants  (dgrants),
`endif
        .ramstate (ramstate)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int next_core(input logic [CPUS-1:0] req, input int last);
        for (int n = 1; n <= CPUS; n++) begin
            if (req[(last + n) % CPUS]) return (last + n) % CPUS;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_isd  = 0;
        m_core = 0;
        m_dptr = CPUS - 1;
        m_iptr = CPUS - 1;
        m_icnt = 0;
        m_dcnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_iwait"}, 64'(iwait), 64'(2'b11));
        check_eq({tag, "_dwait"}, 64'(dwait), 64'(2'b11));
        check_eq({tag, "_ren"}, 64'(ramREN), 64'd0);
        check_eq({tag, "_wen"}, 64'(ramWEN), 64'd0);
        check_eq({tag, "_addr"}, 64'(ramaddr), 64'd0);
        check_eq({tag, "_store"}, 64'(ramstore), 64'd0);
`ifdef ARB_PERF_EN
        check_eq({tag, "_igrants"}, 64'(igrants), 64'd0);
        check_eq({tag, "_dgrants"}, 64'(dgrants), 64'd0);
`endif
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the edge.
    task automatic check_and_advance();
        logic [CPUS-1:0] e_iw, e_dw;
        logic            e_ren, e_wen, req, done;
        logic [31:0]     e_addr, e_store;
        int              c;
        e_iw = '1; e_dw = '1; e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        req = 0; done = 0;
        if (m_busy) begin
            if (m_isd) begin
                req    = dREN[m_core] | dWEN[m_core];
                e_addr = daddr[32*m_core +: 32];
                if (req && dWEN[m_core]) begin
                    e_wen   = 1;
                    e_store = dstore[32*m_core +: 32];
                end else if (req) begin
                    e_ren = 1;
                end
                done = req && (ramstate == 2'd2);
                if (done) e_dw[m_core] = 0;
            end else begin
                req    = iREN[m_core];
                e_addr = iaddr[32*m_core +: 32];
                e_ren  = req;
                done   = req && (ramstate == 2'd2);
                if (done) e_iw[m_core] = 0;
            end
        end
        check_eq("iwait", 64'(iwait), 64'(e_iw));
        check_eq("dwait", 64'(dwait), 64'(e_dw));
        check_eq("ramREN", 64'(ramREN), 64'(e_ren));
        check_eq("ramWEN", 64'(ramWEN), 64'(e_wen));
        check_eq("ramaddr", 64'(ramaddr), 64'(e_addr));
        check_eq("ramstore", 64'(ramstore), 64'(e_store));
        check_eq("iload", iload, {ramload, ramload});
        check_eq("dload", dload, {ramload, ramload});
`ifdef ARB_PERF_EN
        check_eq("igrants", 64'(igrants), 64'(m_icnt));
        check_eq("dgrants", 64'(dgrants), 64'(m_dcnt));
`endif
        if (m_busy) begin
            if (!req) begin
                m_busy = 0;
            end else if (done) begin
                m_busy = 0;
                if (m_isd) begin
                    m_dptr = m_core;
                    m_dcnt++;
                end else begin
                    m_iptr = m_core;
                    m_icnt++;
                end
            end
        end else begin
            c = next_core(dREN | dWEN, m_dptr);
            if (c >= 0) begin
                m_busy = 1; m_isd = 1; m_core = c;
            end else begin
                c = next_core(iREN, m_iptr);
                if (c >= 0) begin
                    m_busy = 1; m_isd = 0; m_core = c;
                end
            end
        end
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < CPUS; k++) begin
            if ($urandom_range(3) == 0) iREN[k] = 1'($urandom);
            if ($urandom_range(3) == 0) dREN[k] = 1'($urandom);
            if ($urandom_range(5) == 0) dWEN[k] = 1'($urandom);
        end
        iaddr    = {$urandom, $urandom};
        daddr    = {$urandom, $urandom};
        dstore   = {$urandom, $urandom};
        ramload  = $urandom;
        ramstate = ($urandom_range(1) == 0) ? 2'd2 : 2'($urandom);
    endtask

    initial begin
        int budget;
        nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        // Requests during reset must not reach the RAM.
        iREN = 2'b11; dWEN = 2'b11;
        @(negedge clk);
        check_reset_outputs("reset");
        iREN = 0; dWEN = 0;
        @(posedge clk); #1;
        nRST = 1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            randomize_inputs();
            @(negedge clk);
            check_and_advance();
            @(posedge clk); #1;
        end

        // Reset asserted while a write grant is active.
        iREN = 0; dREN = 0; dWEN = 2'b01; ramstate = 2'd1; daddr = 64'h100;
        dstore = 64'h1234_5678;
        budget = 0;
        while (ramWEN !== 1'b1 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check_eq("midgrant_wen_seen", 64'(ramWEN), 64'd1);
        nRST = 0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        check_reset_outputs("held_reset");
        dWEN = 0;
        model_reset();
        nRST = 1;
        for (int cyc = 0; cyc < 500; cyc++) begin
            randomize_inputs();
            @(negedge clk);
            check_and_advance();
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
